// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit pipelined CPU: opcodes, function-select
// codes, result/branch select encodings and the decoded control word.
package cpu_pkg;

  // Opcodes (IR[15:9])
  localparam logic [6:0] OP_MOV  = 7'h00;
  localparam logic [6:0] OP_ADD  = 7'h02;
  localparam logic [6:0] OP_SHL  = 7'h04;
  localparam logic [6:0] OP_SUB  = 7'h05;
  localparam logic [6:0] OP_AND  = 7'h08;
  localparam logic [6:0] OP_SHR  = 7'h09;
  localparam logic [6:0] OP_OR   = 7'h0A;
  localparam logic [6:0] OP_XOR  = 7'h0C;
  localparam logic [6:0] OP_NOT  = 7'h0E;
  localparam logic [6:0] OP_LD   = 7'h10;
  localparam logic [6:0] OP_ST   = 7'h20;
  localparam logic [6:0] OP_SLT  = 7'h25;
  localparam logic [6:0] OP_ADI  = 7'h42;
  localparam logic [6:0] OP_BRZ  = 7'h60;
  localparam logic [6:0] OP_BRNZ = 7'h61;
  localparam logic [6:0] OP_JMP  = 7'h70;
  localparam logic [6:0] OP_JR   = 7'h71;

  // Function-unit select codes
  localparam logic [3:0] FS_PASS = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SHL  = 4'b0100;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_AND  = 4'b1000;
  localparam logic [3:0] FS_SHR  = 4'b1001;
  localparam logic [3:0] FS_OR   = 4'b1010;
  localparam logic [3:0] FS_XOR  = 4'b1100;
  localparam logic [3:0] FS_NOT  = 4'b1110;

  // Writeback result source
  typedef enum logic [1:0] {
    MD_FU  = 2'b00,
    MD_MEM = 2'b01,
    MD_LT  = 2'b10
  } md_e;

  // Branch kind
  typedef enum logic [1:0] {
    BS_NONE = 2'b00,
    BS_COND = 2'b01,
    BS_JR   = 2'b10,
    BS_JMP  = 2'b11
  } bs_e;

  // Decoded control word carried into execute
  typedef struct packed {
    logic [3:0] fs;
    logic [2:0] sh;
    logic [2:0] da;
    md_e        md;
    logic       rw;
    bs_e        bs;
    logic       ps;
    logic       mw;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    fs: FS_PASS, sh: 3'd0, da: 3'd0, md: MD_FU,
    rw: 1'b0, bs: BS_NONE, ps: 1'b0, mw: 1'b0
  };

  // Branch offset {DR,SB} is a 6-bit two's complement value
  function automatic logic [7:0] sext_off6(input logic [5:0] off);
    return {{2{off[5]}}, off};
  endfunction

endpackage

// File: rtl/regfile_8x8.sv
// 8x8 register file: two combinational read ports, one write port,
// R0 hardwired to zero, write-through bypass from the write port.
module regfile_8x8 #(
  parameter int NREG = 8,
  parameter int DW   = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_i,
  input  logic [AW-1:0] rb_i,
  input  logic [AW-1:0] wa_i,
  input  logic          we_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] rda_o,
  output logic [DW-1:0] rdb_o
);

  logic [DW-1:0] mem_q [NREG];

  // Storage update; writes to R0 are dropped so it always reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else if (we_i && (wa_i != {AW{1'b0}})) begin
      mem_q[wa_i] <= wd_i;
    end else begin
      mem_q[0] <= {DW{1'b0}};
    end
  end

  // Read port A with same-cycle forwarding of the pending write
  always_comb begin
    rda_o = mem_q[ra_i];
    if (ra_i == {AW{1'b0}}) begin
      rda_o = {DW{1'b0}};
    end else if (we_i && (wa_i == ra_i)) begin
      rda_o = wd_i;
    end else begin
      rda_o = mem_q[ra_i];
    end
  end

  // Read port B with same-cycle forwarding of the pending write
  always_comb begin
    rdb_o = mem_q[rb_i];
    if (rb_i == {AW{1'b0}}) begin
      rdb_o = {DW{1'b0}};
    end else if (we_i && (wa_i == rb_i)) begin
      rdb_o = wd_i;
    end else begin
      rdb_o = mem_q[rb_i];
    end
  end

endmodule

// File: rtl/dof_stage.sv
// Decode / operand-fetch stage: decodes IR, reads the register file,
// forms the A/B operand buses and registers the DOF/EX bundle.
module dof_stage
  import cpu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   IR,
  input  logic [DW-1:0] PC_1,
  input  logic          stall,
  input  logic          flush,
  input  logic [2:0]    WB_DA,
  input  logic          WB_RW,
  input  logic [DW-1:0] WB_D,
  output logic [DW-1:0] PC_2,
  output logic [DW-1:0] BuA,
  output logic [DW-1:0] BuB,
  output logic [3:0]    FS,
  output logic [2:0]    SH,
  output logic [2:0]    DA,
  output logic [1:0]    MD,
  output logic          RW,
  output logic [1:0]    BS,
  output logic          PS,
  output logic          MW
);

  logic [6:0]    op_s;
  logic [2:0]    dr_s, sa_s, sb_s;
  logic [DW-1:0] rf_a_s, rf_b_s;
  ctrl_t         dec_ctrl_s;
  logic [DW-1:0] dec_b_s;

  ctrl_t         ctrl_q, ctrl_d;
  logic [DW-1:0] bua_q, bua_d;
  logic [DW-1:0] bub_q, bub_d;
  logic [DW-1:0] pc2_q, pc2_d;

  assign op_s = IR[15:9];
  assign dr_s = IR[8:6];
  assign sa_s = IR[5:3];
  assign sb_s = IR[2:0];

  regfile_8x8 #(.NREG(NREG), .DW(DW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra_i  (sa_s),
    .rb_i  (sb_s),
    .wa_i  (WB_DA),
    .we_i  (WB_RW),
    .wd_i  (WB_D),
    .rda_o (rf_a_s),
    .rdb_o (rf_b_s)
  );

  // Instruction decode: control word and B-operand source
  always_comb begin
    dec_ctrl_s = CTRL_NOP;
    dec_b_s    = rf_b_s;
    case (op_s)
      OP_MOV:  begin dec_ctrl_s.fs = FS_PASS; dec_ctrl_s.rw = 1'b1; dec_ctrl_s.da = dr_s; end
      OP_ADD:  begin dec_ctrl_s.fs = FS_ADD;  dec_ctrl_s.rw = 1'b1; dec_ctrl_s.da = dr_s; end
      OP_SUB:  begin dec_ctrl_s.fs = FS_SUB;  dec_ctrl_s.rw = 1'b1; dec_ctrl_s.da = dr_s; end
      OP_AND:  begin dec_ctrl_s.fs = FS_AND;  dec_ctrl_s.rw = 1'b1; dec_ctrl_s.da = dr_s; end
      OP_OR:   begin dec_ctrl_s.fs = FS_OR;   dec_ctrl_s.rw = 1'b1; dec_ctrl_s.da = dr_s; end
      OP_XOR:  begin dec_ctrl_s.fs = FS_XOR;  dec_ctrl_s.rw = 1'b1; dec_ctrl_s.da = dr_s; end
      OP_NOT:  begin dec_ctrl_s.fs = FS_NOT;  dec_ctrl_s.rw = 1'b1; dec_ctrl_s.da = dr_s; end
      OP_SHL: begin
        dec_ctrl_s.fs = FS_SHL; dec_ctrl_s.sh = sb_s;
        dec_ctrl_s.rw = 1'b1;   dec_ctrl_s.da = dr_s;
      end
      OP_SHR: begin
        dec_ctrl_s.fs = FS_SHR; dec_ctrl_s.sh = sb_s;
        dec_ctrl_s.rw = 1'b1;   dec_ctrl_s.da = dr_s;
      end
      OP_LD: begin
        dec_ctrl_s.fs = FS_PASS; dec_ctrl_s.md = MD_MEM;
        dec_ctrl_s.rw = 1'b1;    dec_ctrl_s.da = dr_s;
      end
      OP_ST: begin
        dec_ctrl_s.mw = 1'b1; dec_ctrl_s.da = dr_s;
      end
      OP_ADI: begin
        dec_ctrl_s.fs = FS_ADD; dec_ctrl_s.rw = 1'b1; dec_ctrl_s.da = dr_s;
        dec_b_s = {{(DW-3){1'b0}}, sb_s};
      end
      OP_SLT: begin
        dec_ctrl_s.fs = FS_SUB; dec_ctrl_s.md = MD_LT;
        dec_ctrl_s.rw = 1'b1;   dec_ctrl_s.da = dr_s;
      end
      // Branches keep DA=0 and RW=0 from the NOP defaults
      OP_BRZ: begin
        dec_ctrl_s.bs = BS_COND; dec_ctrl_s.ps = 1'b1;
        dec_b_s = sext_off6({dr_s, sb_s});
      end
      OP_BRNZ: begin
        dec_ctrl_s.bs = BS_COND; dec_ctrl_s.ps = 1'b0;
        dec_b_s = sext_off6({dr_s, sb_s});
      end
      OP_JMP: begin
        dec_ctrl_s.bs = BS_JMP;
        dec_b_s = sext_off6({dr_s, sb_s});
      end
      OP_JR: begin
        dec_ctrl_s.bs = BS_JR;
      end
      default: begin
        dec_ctrl_s = CTRL_NOP;
      end
    endcase
  end

  // Pipeline-register next state: flush beats stall; flush still loads operands
  always_comb begin
    ctrl_d = ctrl_q;
    bua_d  = bua_q;
    bub_d  = bub_q;
    pc2_d  = pc2_q;
    if (flush) begin
      ctrl_d = CTRL_NOP;
      bua_d  = rf_a_s;
      bub_d  = dec_b_s;
      pc2_d  = PC_1;
    end else if (stall) begin
      ctrl_d = ctrl_q;
      bua_d  = bua_q;
      bub_d  = bub_q;
      pc2_d  = pc2_q;
    end else begin
      ctrl_d = dec_ctrl_s;
      bua_d  = rf_a_s;
      bub_d  = dec_b_s;
      pc2_d  = PC_1;
    end
  end

  // DOF/EX pipeline register; reset value is the NOP bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CTRL_NOP;
      bua_q  <= {DW{1'b0}};
      bub_q  <= {DW{1'b0}};
      pc2_q  <= {DW{1'b0}};
    end else begin
      ctrl_q <= ctrl_d;
      bua_q  <= bua_d;
      bub_q  <= bub_d;
      pc2_q  <= pc2_d;
    end
  end

  assign PC_2 = pc2_q;
  assign BuA  = bua_q;
  assign BuB  = bub_q;
  assign FS   = ctrl_q.fs;
  assign SH   = ctrl_q.sh;
  assign DA   = ctrl_q.da;
  assign MD   = ctrl_q.md;
  assign RW   = ctrl_q.rw;
  assign BS   = ctrl_q.bs;
  assign PS   = ctrl_q.ps;
  assign MW   = ctrl_q.mw;

endmodule

// File: tb/tb_dof_stage.sv
// Scoreboard bench for dof_stage: the driver pushes the expected bundle for
// each clock edge, an independent monitor pops and compares after the edge.
module tb_dof_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] IR = 16'h0;
  logic [7:0]  PC_1 = 8'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  WB_DA = 3'd0;
  logic        WB_RW = 1'b0;
  logic [7:0]  WB_D = 8'h0;
  logic [7:0]  PC_2, BuA, BuB;
  logic [3:0]  FS;
  logic [2:0]  SH, DA;
  logic [1:0]  MD, BS;
  logic        RW, PS, MW;

  always #5 clk = ~clk;

  dof_stage dut (
    .clk(clk), .rst(rst), .IR(IR), .PC_1(PC_1), .stall(stall), .flush(flush),
    .WB_DA(WB_DA), .WB_RW(WB_RW), .WB_D(WB_D),
    .PC_2(PC_2), .BuA(BuA), .BuB(BuB), .FS(FS), .SH(SH), .DA(DA),
    .MD(MD), .RW(RW), .BS(BS), .PS(PS), .MW(MW)
  );

  typedef struct packed {
    logic [7:0] pc2, bua, bub;
    logic [3:0] fs;
    logic [2:0] sh, da;
    logic [1:0] md;
    logic       rw;
    logic [1:0] bs;
    logic       ps, mw;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       last_e;
  exp_t       mon_e, mon_o;
  logic [7:0] regs [8];
  int         vectors = 0;
  int         miscompares = 0;

  logic [6:0] valid_ops [17] = '{7'h00, 7'h02, 7'h05, 7'h08, 7'h0A, 7'h0C, 7'h0E, 7'h04,
                                 7'h09, 7'h10, 7'h20, 7'h42, 7'h25, 7'h60, 7'h61, 7'h70, 7'h71};

  function automatic exp_t observed();
    exp_t o;
    o.pc2 = PC_2; o.bua = BuA; o.bub = BuB; o.fs = FS; o.sh = SH; o.da = DA;
    o.md = MD; o.rw = RW; o.bs = BS; o.ps = PS; o.mw = MW;
    return o;
  endfunction

  function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] dr,
                                     input logic [2:0] sa, input logic [2:0] sb);
    return {op, dr, sa, sb};
  endfunction

  // Architectural register value as seen by a read this cycle
  function automatic logic [7:0] rd(input logic [2:0] r);
    if (r == 3'd0) return 8'h00;
    if (WB_RW && WB_DA == r) return WB_D;
    return regs[r];
  endfunction

  // Reference decode: what the instruction means, straight from the ISA table
  function automatic exp_t model(input logic [15:0] ir, input logic [7:0] pc1);
    exp_t       e;
    logic [6:0] op = ir[15:9];
    logic [2:0] dr = ir[8:6];
    logic [2:0] sa = ir[5:3];
    logic [2:0] sb = ir[2:0];
    int         off = $signed({dr, sb});
    e = '0;
    e.pc2 = pc1;
    e.bua = rd(sa);
    e.bub = rd(sb);
    case (op)
      7'h00: begin e.fs = 4'b0000; e.rw = 1'b1; e.da = dr; end
      7'h02: begin e.fs = 4'b0010; e.rw = 1'b1; e.da = dr; end
      7'h05: begin e.fs = 4'b0101; e.rw = 1'b1; e.da = dr; end
      7'h08: begin e.fs = 4'b1000; e.rw = 1'b1; e.da = dr; end
      7'h0A: begin e.fs = 4'b1010; e.rw = 1'b1; e.da = dr; end
      7'h0C: begin e.fs = 4'b1100; e.rw = 1'b1; e.da = dr; end
      7'h0E: begin e.fs = 4'b1110; e.rw = 1'b1; e.da = dr; end
      7'h04: begin e.fs = 4'b0100; e.sh = sb; e.rw = 1'b1; e.da = dr; end
      7'h09: begin e.fs = 4'b1001; e.sh = sb; e.rw = 1'b1; e.da = dr; end
      7'h10: begin e.md = 2'b01; e.rw = 1'b1; e.da = dr; end
      7'h20: begin e.mw = 1'b1; e.da = dr; end
      7'h42: begin e.fs = 4'b0010; e.rw = 1'b1; e.da = dr; e.bub = 8'(sb); end
      7'h25: begin e.fs = 4'b0101; e.md = 2'b10; e.rw = 1'b1; e.da = dr; end
      7'h60: begin e.bs = 2'b01; e.ps = 1'b1; e.bub = 8'(off); end
      7'h61: begin e.bs = 2'b01; e.ps = 1'b0; e.bub = 8'(off); end
      7'h70: begin e.bs = 2'b11; e.bub = 8'(off); end
      7'h71: begin e.bs = 2'b10; end
      default: begin e.bua = rd(sa); end
    endcase
    return e;
  endfunction

  // One cycle of stimulus: starts and ends at a falling edge
  task automatic step(input logic [15:0] ir, input logic [7:0] pc1, input logic st,
                      input logic fl, input logic [2:0] wda, input logic wrw,
                      input logic [7:0] wd);
    exp_t e;
    IR = ir; PC_1 = pc1; stall = st; flush = fl; WB_DA = wda; WB_RW = wrw; WB_D = wd;
    if (fl) begin
      e = model(ir, pc1);
      e.fs = 4'b0; e.sh = 3'b0; e.da = 3'b0; e.md = 2'b0;
      e.rw = 1'b0; e.bs = 2'b0; e.ps = 1'b0; e.mw = 1'b0;
    end else if (st) begin
      e = last_e;
    end else begin
      e = model(ir, pc1);
    end
    last_e = e;
    sb_q.push_back(e);
    @(posedge clk);
    if (wrw && wda != 3'd0) regs[wda] = wd;
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    exp_t o = observed();
    vectors++;
    if (o !== '0) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, o, 41'h0);
    end
  endtask

  // Asynchronous reset issued at a falling edge with a live instruction present
  task automatic do_reset();
    IR = mk(7'h02, 3'd1, 3'd3, 3'd3); PC_1 = 8'h33;
    WB_DA = 3'd5; WB_RW = 1'b1; WB_D = 8'hAA;
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    WB_RW = 1'b0; stall = 1'b0; flush = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    last_e = '0;
  endtask

  // Monitor: compare the DUT bundle one time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (!rst && sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_o = observed();
      vectors++;
      if (mon_o !== mon_e) begin
        miscompares++;
        $display("FAIL bundle: got pc2=%h A=%h B=%h fs=%b sh=%0d da=%0d md=%b rw=%b bs=%b ps=%b mw=%b expected pc2=%h A=%h B=%h fs=%b sh=%0d da=%0d md=%b rw=%b bs=%b ps=%b mw=%b",
                 mon_o.pc2, mon_o.bua, mon_o.bub, mon_o.fs, mon_o.sh, mon_o.da, mon_o.md,
                 mon_o.rw, mon_o.bs, mon_o.ps, mon_o.mw,
                 mon_e.pc2, mon_e.bua, mon_e.bub, mon_e.fs, mon_e.sh, mon_e.da, mon_e.md,
                 mon_e.rw, mon_e.bs, mon_e.ps, mon_e.mw);
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // R1..R7 read zero after reset
    for (int i = 1; i < 8; i++) step(mk(7'h00, 3'd1, 3'(i), 3'(i)), 8'(i), 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);

    // Writeback R3 then ADD R1 = R3 + R3
    step(mk(7'h7F, 3'd0, 3'd0, 3'd0), 8'h01, 1'b0, 1'b0, 3'd3, 1'b1, 8'h5A);
    step(mk(7'h02, 3'd1, 3'd3, 3'd3), 8'h02, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    // Same-cycle bypass into MOV SA=2
    step(mk(7'h00, 3'd4, 3'd2, 3'd0), 8'h03, 1'b0, 1'b0, 3'd2, 1'b1, 8'h77);
    // R0 write ignored
    step(mk(7'h7F, 3'd0, 3'd0, 3'd0), 8'h04, 1'b0, 1'b0, 3'd0, 1'b1, 8'hFF);
    step(mk(7'h00, 3'd5, 3'd0, 3'd0), 8'h05, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    // Immediate and branch offsets
    step(mk(7'h42, 3'd1, 3'd3, 3'd5), 8'h06, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    step(mk(7'h60, 3'b111, 3'd2, 3'b110), 8'h10, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    step(mk(7'h70, 3'b011, 3'd2, 3'b111), 8'h11, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    // Stall held three cycles with changing IR
    step(mk(7'h02, 3'd1, 3'd3, 3'd3), 8'h20, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    step(mk(7'h04, 3'd6, 3'd2, 3'd3), 8'h21, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
    step(mk(7'h20, 3'd7, 3'd1, 3'd2), 8'h22, 1'b1, 1'b0, 3'd6, 1'b1, 8'h99);
    step(mk(7'h71, 3'd2, 3'd6, 3'd6), 8'h23, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
    // Flush together with stall, then undefined opcode
    step(mk(7'h10, 3'd3, 3'd6, 3'd3), 8'h24, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00);
    step(mk(7'h7F, 3'd7, 3'd7, 3'd7), 8'h25, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);

    // Mid-stream reset, then registers must read zero again
    step(mk(7'h02, 3'd1, 3'd3, 3'd6), 8'h30, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    do_reset();
    for (int i = 1; i < 8; i++) step(mk(7'h00, 3'd2, 3'(i), 3'(8 - i)), 8'h40, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 9) < 8) ? valid_ops[$urandom_range(0, 16)] : 7'($urandom);
      step(mk(op, 3'($urandom), 3'($urandom), 3'($urandom)), 8'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
           3'($urandom), ($urandom_range(0, 2) != 0), 8'($urandom));
    end

    // Bounded drain of any outstanding expectation
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dof_stage.md
Name: dof_stage

Overview:
- Decode/operand-fetch stage of the 8-bit pipelined CPU; the producer side of the execute-stage input bundle.
- Takes the 16-bit instruction and PC from fetch. Decodes the control word, reads the 8x8 register file, forms the A/B operand buses, and registers everything into the DOF/EX pipeline register.
- Owns the register file. The write port is driven by writeback.

Parameters:
- NREG, 8, number of architectural registers; R0 reads as 0.
- DW, 8, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- IR  in  16  instruction from fetch.
- PC_1  in  8  PC+1 of the instruction in IR.
- stall  in  1  hold pipeline register and ignore IR.
- flush  in  1  load bubble (NOP) into pipeline register.
- WB_DA  in  3  writeback destination.
- WB_RW  in  1  writeback write enable.
- WB_D  in  8  writeback data.
- PC_2  out  8  registered PC_1.
- BuA  out  8  registered A operand.
- BuB  out  8  registered B operand.
- FS  out  4  function select.
- SH  out  3  shift amount.
- DA  out  3  destination register.
- MD  out  2  result select: 00 function unit, 01 memory, 10 LT.
- RW  out  1  register write.
- BS  out  2  branch select: 00 none, 01 conditional, 10 jump-register, 11 branch-always.
- PS  out  1  condition polarity: 1 branch on Z, 0 branch on ~Z.
- MW  out  1  memory write.

Behaviour:
- Instruction fields: OP=IR[15:9], DR=IR[8:6], SA=IR[5:3], SB=IR[2:0].
- Decode table. Any opcode not listed decodes as NOP.
  - 0x00 MOV: FS 0000, RW 1, MD 00.
  - 0x02 ADD: FS 0010, RW 1.
  - 0x05 SUB: FS 0101, RW 1.
  - 0x08 AND: FS 1000, RW 1.
  - 0x0A OR: FS 1010, RW 1.
  - 0x0C XOR: FS 1100, RW 1.
  - 0x0E NOT: FS 1110, RW 1.
  - 0x04 SHL: FS 0100, SH=SB, RW 1.
  - 0x09 SHR: FS 1001, SH=SB, RW 1.
  - 0x10 LD: FS 0000, MD 01, RW 1.
  - 0x20 ST: MW 1, RW 0.
  - 0x42 ADI: FS 0010, B=zero-extended SB, RW 1.
  - 0x25 SLT: FS 0101, MD 10, RW 1.
  - 0x60 BRZ: BS 01, PS 1, FS 0000.
  - 0x61 BRNZ: BS 01, PS 0, FS 0000.
  - 0x70 JMP: BS 11.
  - 0x71 JR: BS 10.
- NOP control word: FS 0000, SH 0, DA 0, MD 00, RW 0, BS 00, PS 0, MW 0.
- B operand selection:
  - Register instructions: B = R[SB].
  - ADI: B = {5'b0,SB}.
  - BRZ/BRNZ/JMP: B = sign-extended {DR,SB} (6-bit offset, range -32..+31).
  - For branches, DA is forced to 0 and RW to 0.
- A operand: always R[SA]. SH is 0 unless the instruction is SHL or SHR.
- Register file:
  - 8x8; R0 is hardwired to 0, and writes to R0 are ignored.
  - Written on the rising edge when WB_RW=1.
  - Write-through bypass: if WB_RW=1, WB_DA==SA (or SB) and WB_DA!=0, that read returns WB_D in the same cycle.
- Pipeline register, latency 1 cycle IR->outputs. Per rising edge, priority is rst > flush > stall > normal:
  - flush: load NOP control word; BuA, BuB, PC_2 take the new decoded values (don't-care, but deterministic).
  - stall: hold all outputs.
  - flush and stall together: flush wins.
- The register file write is never blocked by stall or flush.
- Reset, asynchronous:
  - All outputs 0, which equals NOP.
  - All registers 0.
  - Reset asserted mid-stream discards the in-flight instruction.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_MOV…OP_JR);
  - FS codes (FS_PASS=0000, FS_ADD=0010, FS_SUB=0101, FS_SHL=0100, FS_SHR=1001, FS_AND=1000, FS_OR=1010, FS_XOR=1100, FS_NOT=1110);
  - BS/MD encodings;
  - a packed control-word typedef and the NOP constant.
- One sub-module, regfile_8x8: two read ports, one write port, bypass logic.
- Decode stays as a combinational case inside dof_stage.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; R1..R7 read 0 afterwards.
- Writeback then read: WB R3=0x5A, then IR=ADD DR=1 SA=3 SB=3 -> next edge BuA=0x5A, BuB=0x5A, FS=0010, DA=1, RW=1.
- Bypass: WB_RW=1 WB_DA=2 WB_D=0x77 in the same cycle as IR=MOV SA=2 -> BuA=0x77 one cycle later.
- R0 write ignored: WB to R0 with 0xFF, then MOV SA=0 -> BuA=0x00.
- Immediate and branch operand forms:
  - ADI SB=5 -> BuB=0x05.
  - BRZ {DR,SB}=6'b111110 with PC_1=0x10 -> BuB=0xFE, PC_2=0x10, BS=01, PS=1, RW=0.
- Stall/flush:
  - stall held 3 cycles with changing IR -> outputs frozen.
  - flush together with stall -> NOP control word (RW=0, MW=0, BS=00).
  - undefined opcode 0x7F -> NOP.
